// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM states,
// event layout {ext, brk, code} and the two prefix scan codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int EVT_W = 10;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Event FIFO, first-word-fall-through, power-of-two depth; rd_dat reads zero when empty.
// Latency: a write is visible on rd_vld/rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy drops when full unless a read retires a word in the same cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign rd_vld = (cnt != '0);
    assign do_rd  = rd_vld & rd_rdy;
    assign wr_rdy = ~full | do_rd;
    assign do_wr  = wr_vld & wr_rdy;
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: rd_dat is masked while the FIFO is empty.
    always_ff @(posedge core_clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, E0/F0 decoder, event FIFO (PS2_PARITY_CHK_EN adds odd-parity check).
// Latency: FIFO push one cycle after the STOP edge is detected, o_valid the cycle after that.
// Backpressure: i_ready pops the FIFO; a push into a full FIFO is dropped and sets sticky o_ovf.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int TIMEOUT_US = 2000,
    parameter int FILT_CYC   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             PS2Clk,
    input  logic             PS2Data,
    output logic [EVT_W-1:0] o_evt,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_err,
    output logic             o_ovf,
    input  logic             i_clr
);

    localparam longint TO_LONG = (longint'(TIMEOUT_US) * longint'(CLK_HZ)) / 64'd1000000;
    localparam int     TO_W    = (TO_LONG < 2) ? 1 : $clog2(TO_LONG + 1);
    localparam logic [TO_W-1:0] TO_CYC = TO_W'(TO_LONG);
    localparam int     FW      = $clog2(FILT_CYC + 1);

    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            filt_lvl, filt_prev;
    logic [FW-1:0]   filt_cnt;
    logic            fall;

    ps2_state_t      state, state_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            frame_ok, abort;
    logic            par_ok;

    logic            done_vld;
    logic [7:0]      done_code;
    logic            ext_flg, brk_flg;
    logic            push, push_rdy;
    evt_t            push_evt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_lvl  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_s1    <= PS2Clk;
            clk_s2    <= clk_s1;
            dat_s1    <= PS2Data;
            dat_s2    <= dat_s1;
            filt_prev <= filt_lvl;
            // Accept a new clock level only after FILT_CYC consecutive agreeing samples.
            if (clk_s2 == filt_lvl) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_CYC - 1)) begin
                filt_lvl <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_lvl;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        frame_ok    = 1'b0;
        abort       = 1'b0;
        if (state != IDLE && !fall && to_cnt == TO_CYC) begin
            abort     = 1'b1;
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shreg_nxt   = {dat_s2, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (dat_s2 && par_ok) frame_ok = 1'b1;
                    else                  abort    = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef PS2_PARITY_CHK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                      par_ok <= 1'b0;
        else if (fall && state == PARITY)  par_ok <= ^{shreg, dat_s2};
    end
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            to_cnt    <= '0;
            done_vld  <= 1'b0;
            done_code <= '0;
            o_err     <= 1'b0;
            ext_flg   <= 1'b0;
            brk_flg   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            done_vld <= frame_ok;
            o_err    <= abort;
            if (frame_ok) done_code <= shreg;
            // The gap timer restarts on every edge and is idle outside a frame.
            if (state_nxt == IDLE || fall) to_cnt <= '0;
            else if (to_cnt != TO_CYC)     to_cnt <= to_cnt + 1'b1;
            if (abort) begin
                ext_flg <= 1'b0;
                brk_flg <= 1'b0;
            end else if (done_vld) begin
                if (done_code == PS2_EXT) begin
                    ext_flg <= 1'b1;
                end else if (done_code == PS2_BRK) begin
                    brk_flg <= 1'b1;
                end else begin
                    ext_flg <= 1'b0;
                    brk_flg <= 1'b0;
                end
            end
        end
    end

    assign push     = done_vld && (done_code != PS2_EXT) && (done_code != PS2_BRK);
    assign push_evt = {ext_flg, brk_flg, done_code};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)              o_ovf <= 1'b0;
        else if (push && !push_rdy) o_ovf <= 1'b1;
        else if (i_clr)             o_ovf <= 1'b0;
    end

    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .wr_vld   (push),
        .wr_rdy   (push_rdy),
        .wr_dat   (push_evt),
        .rd_vld   (o_valid),
        .rd_rdy   (i_ready),
        .rd_dat   (o_evt)
    );

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: drives PS/2 frames bit by bit and checks decoded events,
// error pulses, overflow and reset against a byte-level reference model.
module tb_ps2_key_ctrl;

    localparam int CLK_HZ     = 1000000;
    localparam int TIMEOUT_US = 300;
    localparam int FILT_CYC   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TO_CYC     = TIMEOUT_US * CLK_HZ / 1000000;
    localparam int HALF       = 20;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rdy     = 1'b0;
    logic       clr     = 1'b0;
    logic [9:0] evt;
    logic       vld;
    logic       err;
    logic       ovf;

    int         n_cmp   = 0;
    int         n_bad   = 0;
    int         rdy_mode = 1;
    int         err_cnt = 0;
    logic [9:0] got[$];
    logic [7:0] tx[$];
    logic [9:0] exp_q[$];

    ps2_key_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US),
        .FILT_CYC   (FILT_CYC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .PS2Clk  (ps2_clk),
        .PS2Data (ps2_dat),
        .o_evt   (evt),
        .o_valid (vld),
        .i_ready (rdy),
        .o_err   (err),
        .o_ovf   (ovf),
        .i_clr   (clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = ($urandom_range(0, 1) == 1);
        endcase
    end

    always @(negedge clk) begin
        if (vld && rdy) got.push_back(evt);
        if (err) err_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    task automatic ps2_bit(input logic b);
        @(posedge clk); #2; ps2_dat = b;
        repeat (HALF) @(posedge clk);
        #2; ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #2; ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par);
        logic par;
        par = ~^code;
        if (bad_par) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        repeat (HALF) @(posedge clk);
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 3000 && got.size() < n; i++) @(posedge clk);
        repeat (10) @(posedge clk);
    endtask

    function automatic logic [7:0] plain_code();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == 8'hE0 || c == 8'hF0);
        return c;
    endfunction

    // Byte-level decode: prefixes accumulate, any other byte emits and clears them.
    task automatic model_run();
        bit e, b;
        e = 0; b = 0;
        exp_q.delete();
        foreach (tx[i]) begin
            if (tx[i] == 8'hE0)      e = 1;
            else if (tx[i] == 8'hF0) b = 1;
            else begin
                exp_q.push_back({e, b, tx[i]});
                e = 0; b = 0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (vld !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", vld); end
        n_cmp++; if (evt !== 10'h000) begin n_bad++; $display("FAIL reset_evt: got %h expected 000", evt); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_single();
        int base, e0, lat;
        logic [7:0] code;
        base = got.size(); e0 = err_cnt; lat = 0; code = 8'h1C;
        rdy_mode = 1;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(~^code);
        @(posedge clk); #2; ps2_dat = 1'b1;
        repeat (HALF) @(posedge clk);
        #2; ps2_clk = 1'b0;
        for (int i = 1; i <= HALF && lat == 0; i++) begin
            @(negedge clk);
            if (vld) lat = i;
        end
        repeat (HALF) @(posedge clk);
        #2; ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        n_cmp++; if (lat < FILT_CYC + 4 || lat > FILT_CYC + 6) begin n_bad++;
            $display("FAIL single_latency: got %0d cycles expected %0d..%0d", lat, FILT_CYC + 4, FILT_CYC + 6); end
        n_cmp++; if (got.size() != base + 1) begin n_bad++;
            $display("FAIL single_count: got %0d expected %0d", got.size() - base, 1); end
        else begin
            n_cmp++; if (got[base] !== 10'h01C) begin n_bad++; $display("FAIL single_evt: got %h expected 01c", got[base]); end
        end
        n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL single_err: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_ext_brk();
        int base;
        base = got.size();
        tx.delete();
        tx.push_back(8'hE0); tx.push_back(8'hF0); tx.push_back(8'h75); tx.push_back(8'h1C);
        model_run();
        foreach (tx[i]) send_frame(tx[i], 0);
        wait_got(base + exp_q.size());
        n_cmp++; if (got.size() != base + exp_q.size()) begin n_bad++;
            $display("FAIL extbrk_count: got %0d expected %0d", got.size() - base, exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_cmp++; if (got[base + i] !== exp_q[i]) begin n_bad++;
                $display("FAIL extbrk_evt%0d: got %h expected %h", i, got[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_timeout();
        int base, e0;
        logic [7:0] code;
        code = 8'h1C;
        send_frame(8'hE0, 0);
        base = got.size(); e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(code[i]);
        repeat (2 * TO_CYC) @(posedge clk);
        n_cmp++; if (err_cnt != e0 + 1) begin n_bad++;
            $display("FAIL timeout_err: got %0d pulses expected 1", err_cnt - e0); end
        n_cmp++; if (got.size() != base) begin n_bad++;
            $display("FAIL timeout_noevt: got %0d events expected 0", got.size() - base); end
        send_frame(8'h1C, 0);
        wait_got(base + 1);
        n_cmp++; if (got.size() != base + 1) begin n_bad++;
            $display("FAIL timeout_next_count: got %0d expected 1", got.size() - base); end
        else begin
            n_cmp++; if (got[base] !== 10'h01C) begin n_bad++; $display("FAIL timeout_next_evt: got %h expected 01c", got[base]); end
        end
        n_cmp++; if (err_cnt != e0 + 1) begin n_bad++;
            $display("FAIL timeout_next_err: got %0d pulses expected 1", err_cnt - e0); end
    endtask

    task automatic test_parity();
        int base, e0;
        base = got.size(); e0 = err_cnt;
        send_frame(8'h1C, 1);
        repeat (40) @(posedge clk);
`ifdef PS2_PARITY_CHK_EN
        n_cmp++; if (err_cnt != e0 + 1) begin n_bad++;
            $display("FAIL parity_err: got %0d pulses expected 1", err_cnt - e0); end
        n_cmp++; if (got.size() != base) begin n_bad++;
            $display("FAIL parity_noevt: got %0d events expected 0", got.size() - base); end
`else
        n_cmp++; if (err_cnt != e0) begin n_bad++;
            $display("FAIL parity_err: got %0d pulses expected 0", err_cnt - e0); end
        n_cmp++; if (got.size() != base + 1) begin n_bad++;
            $display("FAIL parity_count: got %0d events expected 1", got.size() - base); end
        else begin
            n_cmp++; if (got[base] !== 10'h01C) begin n_bad++; $display("FAIL parity_evt: got %h expected 01c", got[base]); end
        end
`endif
    endtask

    task automatic test_overflow();
        int base;
        logic [7:0] codes[$];
        base = got.size();
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        for (int i = 0; i <= FIFO_DEPTH; i++) codes.push_back(plain_code());
        foreach (codes[i]) send_frame(codes[i], 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL ovf_valid: got %b expected 1", vld); end
        n_cmp++; if (evt !== {2'b00, codes[0]}) begin n_bad++; $display("FAIL ovf_head: got %h expected %h", evt, {2'b00, codes[0]}); end
        repeat (7) @(negedge clk);
        n_cmp++; if (evt !== {2'b00, codes[0]}) begin n_bad++; $display("FAIL ovf_hold: got %h expected %h", evt, {2'b00, codes[0]}); end
        @(posedge clk); #2; clr = 1'b1;
        @(posedge clk); #2; clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
        rdy_mode = 1;
        wait_got(base + FIFO_DEPTH);
        repeat (20) @(posedge clk);
        n_cmp++; if (got.size() != base + FIFO_DEPTH) begin n_bad++;
            $display("FAIL ovf_count: got %0d expected %0d", got.size() - base, FIFO_DEPTH); end
        else for (int i = 0; i < FIFO_DEPTH; i++) begin
            n_cmp++; if (got[base + i] !== {2'b00, codes[i]}) begin n_bad++;
                $display("FAIL ovf_evt%0d: got %h expected %h", i, got[base + i], {2'b00, codes[i]}); end
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        logic [7:0] code;
        code = 8'h1C;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(code[i]);
        @(posedge clk); #2; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({vld, evt, err, ovf} !== 13'h0) begin n_bad++;
            $display("FAIL midrst_outs: got vld=%b evt=%h err=%b ovf=%b expected all 0", vld, evt, err, ovf); end
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (10) @(posedge clk);
        base = got.size();
        send_frame(8'h1C, 0);
        wait_got(base + 1);
        n_cmp++; if (got.size() != base + 1) begin n_bad++;
            $display("FAIL midrst_count: got %0d expected 1", got.size() - base); end
        else begin
            n_cmp++; if (got[base] !== 10'h01C) begin n_bad++; $display("FAIL midrst_evt: got %h expected 01c", got[base]); end
        end
    endtask

    task automatic test_random();
        int base, e0, r;
        base = got.size(); e0 = err_cnt;
        tx.delete();
        for (int i = 0; i < 11; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      tx.push_back(8'hE0);
            else if (r < 4) tx.push_back(8'hF0);
            else            tx.push_back(plain_code());
        end
        tx.push_back(plain_code());
        model_run();
        rdy_mode = 2;
        foreach (tx[i]) send_frame(tx[i], 0);
        rdy_mode = 1;
        wait_got(base + exp_q.size());
        n_cmp++; if (got.size() != base + exp_q.size()) begin n_bad++;
            $display("FAIL rand_count: got %0d expected %0d", got.size() - base, exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_cmp++; if (got[base + i] !== exp_q[i]) begin n_bad++;
                $display("FAIL rand_evt%0d: got %h expected %h", i, got[base + i], exp_q[i]); end
        end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rand_ovf: got %b expected 0", ovf); end
        n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL rand_err: got %0d pulses expected 0", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ext_brk();
        test_timeout();
        test_parity();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
